// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory controller:
// FSM state codes, default widths and per-state memory pin encodings.
package instr_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_RD_ADDR = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  typedef struct packed {
    logic cs;
    logic we;
    logic oe;
  } mem_ctl_t;

  localparam mem_ctl_t CTL_IDLE    = 3'b000;
  localparam mem_ctl_t CTL_WRITE   = 3'b110;
  localparam mem_ctl_t CTL_RD_ADDR = 3'b100;
  localparam mem_ctl_t CTL_RD_DATA = 3'b101;

  function automatic mem_ctl_t ctl_of(input logic [1:0] st);
    mem_ctl_t c;
    c = CTL_IDLE;
    case (st)
      ST_WRITE:   c = CTL_WRITE;
      ST_RD_ADDR: c = CTL_RD_ADDR;
      ST_RD_DATA: c = CTL_RD_DATA;
      default:    c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with one-hot grant.
// Ports: clk, rst (sync, high), i_en (arbitrate), i_req[1:0]
// (bit0 loader, bit1 fetch), o_gnt[1:0] one-hot grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Set when the loader owns priority on a tie.
  logic r_prio_ld;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11)
        o_gnt = r_prio_ld ? 2'b01 : 2'b10;
      else
        o_gnt = i_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_prio_ld <= 1'b1;
    else if (|o_gnt)
      r_prio_ld <= o_gnt[1];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Arbitrates a loader (write) port and a fetch (read) port onto
// a single tri-state synchronous instruction memory.
// Ports: clk, rst (sync, high); loader ld_req/ld_addr/ld_wdata/
// ld_ack; fetch f_req/f_addr/f_valid/f_rdata; memory mem_cs,
// mem_we, mem_oe, mem_addr, mem_data (inout).
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fvalid;

  logic              w_idle;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  mem_ctl_t          w_ctl;

  assign w_idle = (r_state == ST_IDLE);

  // The fetcher still holds f_req in its f_valid cycle;
  // mask it so the same read is not granted twice.
  assign w_req = {f_req & ~r_fvalid, ld_req};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_idle),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_fvalid <= 1'b0;
    end else begin
      r_fvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt[0]) begin
            r_state <= ST_WRITE;
            r_addr  <= ld_addr;
            r_wdata <= ld_wdata;
          end else if (w_gnt[1]) begin
            r_state <= ST_RD_ADDR;
            r_addr  <= f_addr;
          end
        end
        ST_WRITE:   r_state <= ST_IDLE;
        ST_RD_ADDR: r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          r_state  <= ST_IDLE;
          r_rdata  <= mem_data;
          r_fvalid <= 1'b1;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_ctl    = ctl_of(r_state);
  assign mem_cs   = w_ctl.cs;
  assign mem_we   = w_ctl.we;
  assign mem_oe   = w_ctl.oe;
  assign mem_addr = w_idle ? '0 : r_addr;
  assign mem_data = (r_state == ST_WRITE) ? r_wdata : 'z;
  assign ld_ack   = (r_state == ST_WRITE);
  assign f_valid  = r_fvalid;
  assign f_rdata  = r_rdata;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Testbench for instr_mem_ctrl with a 256x8 tri-state memory
// model, vector table, read scoreboard and arbitration sequences.
module tb_instr_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_req = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_wdata = '0;
  logic       ld_ack;
  logic       f_req = 1'b0;
  logic [7:0] f_addr = '0;
  logic       f_valid;
  logic [7:0] f_rdata;
  logic       mem_cs, mem_we, mem_oe;
  logic [7:0] mem_addr;
  wire  [7:0] mem_data;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_ack   (ld_ack),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_valid  (f_valid),
    .f_rdata  (f_rdata),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // 256x8 memory: registered read, drives bus only when enabled
  logic [7:0] mem [256];
  logic [7:0] m_q;
  always @(posedge clk) begin
    if (mem_cs && mem_we) mem[mem_addr] <= mem_data;
    if (mem_cs && !mem_we) m_q <= mem[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? m_q : 8'hzz;

  int pass = 0;
  int total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endfunction

  // Bus monitor: exclusivity, defined data, address zero in idle
  bit mon_en = 0;
  bit log_en = 0;
  bit log_q[$];
  always @(negedge clk) begin
    if (log_en) begin
      if (mem_we) log_q.push_back(1'b1);
      else if (mem_cs && !mem_oe) log_q.push_back(1'b0);
    end
    if (mon_en) begin
      if (mem_cs) begin
        check("we_oe_excl", {31'd0, mem_we & mem_oe}, 0);
        if (mem_we || mem_oe)
          check("data_known", {31'd0, $isunknown(mem_data)}, 0);
      end else begin
        check("idle_addr0", {24'd0, mem_addr}, 0);
        check("idle_ctl0", {29'd0, mem_cs, mem_we, mem_oe}, 0);
      end
    end
  end

  logic [7:0] sb_q[$];

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input bit chk, output int done_cyc);
    int n = 0;
    done_cyc = 0;
    ld_addr = a; ld_wdata = d; ld_req = 1'b1;
    do begin @(negedge clk); n++; end while (!ld_ack && n < 20);
    ld_req = 1'b0;
    if (!ld_ack) begin
      total++;
      $display("FAIL wr_timeout addr=%0h: no ld_ack, required ack", a);
    end else begin
      done_cyc = cyc;
      if (chk) check("wr_latency", n, 1);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] e,
                         input bit chk, output int done_cyc);
    int n = 0;
    logic [7:0] x;
    done_cyc = 0;
    sb_q.push_back(e);
    f_addr = a; f_req = 1'b1;
    do begin @(negedge clk); n++; end while (!f_valid && n < 20);
    f_req = 1'b0;
    x = sb_q.pop_front();
    if (!f_valid) begin
      total++;
      $display("FAIL rd_timeout addr=%0h: no f_valid, required valid", a);
    end else begin
      done_cyc = cyc;
      check($sformatf("rd_data@%0h", a), f_rdata, x);
      if (chk) check("rd_latency", n, 3);
    end
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cw, cr, d, viol, nw, nr;
    logic [7:0] rexp [4];

    tbl[0]  = '{1, 8'h10, 8'hA5};
    tbl[1]  = '{0, 8'h10, 8'hA5};
    tbl[2]  = '{1, 8'hFF, 8'hFF};
    tbl[3]  = '{1, 8'h00, 8'h01};
    tbl[4]  = '{0, 8'hFF, 8'hFF};
    tbl[5]  = '{0, 8'h00, 8'h01};
    tbl[6]  = '{1, 8'h7F, 8'h3C};
    tbl[7]  = '{1, 8'h01, 8'h5E};
    tbl[8]  = '{0, 8'h7F, 8'h3C};
    tbl[9]  = '{0, 8'h01, 8'h5E};
    tbl[10] = '{1, 8'h02, 8'hC7};
    tbl[11] = '{1, 8'h03, 8'h9B};
    rexp[0] = 8'h01; rexp[1] = 8'h5E;
    rexp[2] = 8'hC7; rexp[3] = 8'h9B;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ld_ack", {31'd0, ld_ack}, 0);
    check("rst_f_valid", {31'd0, f_valid}, 0);
    check("rst_f_rdata", {24'd0, f_rdata}, 0);
    check("rst_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 0);
    check("rst_addr", {24'd0, mem_addr}, 0);
    mon_en = 1;

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, 1, d);
      else do_read(tbl[i].addr, tbl[i].data, 1, d);
      @(negedge clk);
    end

    // Reset in RD_DATA aborts the read
    f_addr = 8'h10; f_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("in_rd_data_oe", {31'd0, mem_oe}, 1);
    rst = 1'b1; f_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_f_valid", {31'd0, f_valid}, 0);
    check("abort_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 0);
    check("abort_addr", {24'd0, mem_addr}, 0);
    check("abort_f_rdata", {24'd0, f_rdata}, 0);
    @(negedge clk);
    check("abort_no_valid", {31'd0, f_valid}, 0);
    do_read(8'h10, 8'hA5, 1, d);
    @(negedge clk);

    // Tie right after reset: loader first
    do_write(8'h21, 8'hC3, 1, d);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork
      do_write(8'h20, 8'h5A, 0, cw);
      do_read(8'h21, 8'hC3, 0, cr);
    join
    check("tie1_ld_first", {31'd0, cw < cr}, 1);
    @(negedge clk);
    do_write(8'h22, 8'h11, 1, d);
    @(negedge clk);
    // Loader went last: fetch wins, sees old data
    fork
      do_write(8'h20, 8'h77, 0, cw);
      do_read(8'h20, 8'h5A, 0, cr);
    join
    check("tie2_f_first", {31'd0, cr < cw}, 1);
    @(negedge clk);
    do_read(8'h20, 8'h77, 1, d);
    @(negedge clk);

    // Both ports held busy: strict alternation
    log_q.delete();
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          do_write(8'h40 + 8'(i), 8'h80 + 8'(i), 0, d);
      end
      begin
        for (int j = 0; j < 4; j++)
          do_read(8'(j), rexp[j], 0, cr);
      end
    join
    log_en = 0;
    viol = 0; nw = 0; nr = 0;
    foreach (log_q[k]) begin
      if (log_q[k]) nw++; else nr++;
      if (k > 0 && log_q[k] == log_q[k-1]) viol++;
    end
    check("alt_writes", nw, 4);
    check("alt_reads", nr, 4);
    check("alt_viol", viol, 0);
    @(negedge clk);
    do_read(8'h43, 8'h83, 1, d);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
